// File: rtl/machine_timer_pkg.sv
// Shared definitions for the machine timer: register offsets, CTRL field
// positions, bus handshake states and the byte-lane merge helper.
package machine_timer_pkg;

  localparam logic [4:0] TIMER_OFF_MTIME_LO    = 5'h00;
  localparam logic [4:0] TIMER_OFF_MTIME_HI    = 5'h04;
  localparam logic [4:0] TIMER_OFF_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] TIMER_OFF_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] TIMER_OFF_CTRL        = 5'h10;

  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_DIV_LO = 16;

  typedef enum logic {
    TB_IDLE = 1'b0,
    TB_ACK  = 1'b1
  } timer_bus_state_t;

  // Replace only the byte lanes selected by be.
  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/machine_timer_prescaler.sv
// Tick prescaler: emits a one-cycle tick every DIV+1 enabled cycles.
module timer_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic [PRESCALE_W-1:0] div_i,
  input  logic                  clear_i,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == div_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)   cnt_d = '0;
    else if (en_i) cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/machine_timer.sv
// Memory-mapped machine timer: 64-bit mtime, mtimecmp, prescaled tick and a
// registered level interrupt, behind a single-outstanding req/ack slave port.
module machine_timer
  import machine_timer_pkg::*;
#(
  parameter int          PRESCALE_W = 16,
  parameter logic [63:0] CMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [4:0]  bus_addr,
  input  logic [3:0]  bus_be,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  output logic        timer_interrupt
);

  timer_bus_state_t      state_q, state_d;
  logic [63:0]           mtime_q, mtime_d;
  logic [63:0]           cmp_q, cmp_d;
  logic [31:0]           snap_q, snap_d;
  logic                  en_q, en_d;
  logic [PRESCALE_W-1:0] div_q, div_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  irq_q;

  logic                  access, wr, rd;
  logic [4:0]            word_off;
  logic [31:0]           ctrl_word, rd_mux;
  logic                  ctrl_wr;
  logic                  tick;

  timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .en_i    (en_q),
    .div_i   (div_q),
    .clear_i (ctrl_wr),
    .tick_o  (tick)
  );

  always_comb begin
    ctrl_word = '0;
    ctrl_word[CTRL_EN_BIT] = en_q;
    ctrl_word[CTRL_DIV_LO +: PRESCALE_W] = div_q;
  end

  always_comb begin
    access   = (state_q == TB_IDLE) && bus_req;
    // An all-zero byte enable is a pure no-op: it must not suppress a tick.
    wr       = access && bus_we && (bus_be != 4'b0000);
    rd       = access && !bus_we;
    word_off = bus_addr & 5'b11100;
    ctrl_wr  = wr && (word_off == TIMER_OFF_CTRL);
  end

  always_comb begin
    rd_mux = '0;
    case (word_off)
      TIMER_OFF_MTIME_LO:    rd_mux = mtime_q[31:0];
      TIMER_OFF_MTIME_HI:    rd_mux = snap_q;
      TIMER_OFF_MTIMECMP_LO: rd_mux = cmp_q[31:0];
      TIMER_OFF_MTIMECMP_HI: rd_mux = cmp_q[63:32];
      TIMER_OFF_CTRL:        rd_mux = ctrl_word;
      default:               rd_mux = '0;
    endcase
  end

  always_comb begin
    state_d = access ? TB_ACK : TB_IDLE;
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    cmp_d   = cmp_q;
    snap_d  = snap_q;
    en_d    = en_q;
    div_d   = div_q;
    rdata_d = rdata_q;

    if (access) rdata_d = rd ? rd_mux : 32'h0;

    // A write to either mtime half drops the concurrent tick entirely,
    // so the untouched half never sees a carry.
    if (wr) begin
      case (word_off)
        TIMER_OFF_MTIME_LO: begin
          mtime_d = {mtime_q[63:32], be_merge(mtime_q[31:0], bus_wdata, bus_be)};
          snap_d  = mtime_q[63:32];
        end
        TIMER_OFF_MTIME_HI: begin
          mtime_d = {be_merge(mtime_q[63:32], bus_wdata, bus_be), mtime_q[31:0]};
          snap_d  = mtime_d[63:32];
        end
        TIMER_OFF_MTIMECMP_LO:
          cmp_d[31:0]  = be_merge(cmp_q[31:0], bus_wdata, bus_be);
        TIMER_OFF_MTIMECMP_HI:
          cmp_d[63:32] = be_merge(cmp_q[63:32], bus_wdata, bus_be);
        TIMER_OFF_CTRL: begin
          if (bus_be[CTRL_EN_BIT / 8]) en_d = bus_wdata[CTRL_EN_BIT];
          for (int i = 0; i < PRESCALE_W; i++) begin
            if (bus_be[(CTRL_DIV_LO + i) / 8]) div_d[i] = bus_wdata[CTRL_DIV_LO + i];
          end
        end
        default: ;
      endcase
    end

    // Reading LO freezes the matching HI so a LO-then-HI pair is coherent.
    if (rd && (word_off == TIMER_OFF_MTIME_LO)) snap_d = mtime_q[63:32];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= TB_IDLE;
      mtime_q <= '0;
      cmp_q   <= CMP_RESET;
      snap_q  <= '0;
      en_q    <= 1'b1;
      div_q   <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      snap_q  <= snap_d;
      en_q    <= en_d;
      div_q   <= div_d;
      rdata_q <= rdata_d;
      irq_q   <= (mtime_q >= cmp_q);
    end
  end

  assign bus_ack         = (state_q == TB_ACK);
  assign bus_rdata       = bus_ack ? rdata_q : 32'h0;
  assign timer_interrupt = irq_q;

endmodule

// File: tb/tb_machine_timer.sv
// Directed bench for machine_timer: reset, interrupt, carry/coherency,
// prescaler, write/tick collision and bus handshake.
module tb_machine_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bus_req = 1'b0;
  logic        bus_we = 1'b0;
  logic [4:0]  bus_addr = '0;
  logic [3:0]  bus_be = '0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        timer_interrupt;

  int unsigned passes = 0;
  int unsigned total  = 0;
  int unsigned cyc    = 0;
  logic        irq_at_ack;
  logic [31:0] rdv;

  localparam logic [4:0] A_MLO = 5'h00, A_MHI = 5'h04, A_CLO = 5'h08,
                         A_CHI = 5'h0C, A_CTRL = 5'h10;

  machine_timer dut (
    .clk             (clk),
    .rst             (rst),
    .bus_req         (bus_req),
    .bus_we          (bus_we),
    .bus_addr        (bus_addr),
    .bus_be          (bus_be),
    .bus_wdata       (bus_wdata),
    .bus_rdata       (bus_rdata),
    .bus_ack         (bus_ack),
    .timer_interrupt (timer_interrupt)
  );

  always #5 clk = ~clk;

  // Posedges since reset release; equals mtime while nothing writes it.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Called at a negedge; returns at the negedge after the ack cycle.
  task automatic bus_xfer(input logic we, input logic [4:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, output logic [31:0] rd);
    int waits;
    waits     = 0;
    bus_req   = 1'b1;
    bus_we    = we;
    bus_addr  = addr;
    bus_be    = be;
    bus_wdata = wd;
    do begin
      @(negedge clk);
      waits++;
    end while (!bus_ack && waits < 8);
    check("ack_latency", waits, 1);
    rd         = bus_rdata;
    irq_at_ack = timer_interrupt;
    bus_req    = 1'b0;
    bus_we     = 1'b0;
    bus_be     = '0;
    @(negedge clk);
    check("ack_one_cycle", bus_ack, 0);
  endtask

  task automatic rd_reg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    logic [31:0] r;
    bus_xfer(1'b0, addr, 4'h0, 32'h0, r);
    check(tag, r, exp);
  endtask

  task automatic wr_reg(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] be);
    logic [31:0] r;
    bus_xfer(1'b1, addr, be, data, r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pre_tab [8];
    pre_tab = '{32'd2, 32'd2, 32'd3, 32'd3, 32'd4, 32'd4, 32'd5, 32'd5};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ack", bus_ack, 0);
    check("rst_rdata", bus_rdata, 0);
    check("rst_irq", timer_interrupt, 0);
    rst = 1'b1;

    // mtime counts from release with DIV = 0; read sampled at the 10th edge
    repeat (9) @(negedge clk);
    rd_reg("mtime_at_cycle10", A_MLO, 32'd9);
    check("irq_quiet_after_reset", timer_interrupt, 0);

    // Interrupt: mtimecmp = 0x20, irq rises one cycle after mtime == 0x20
    wr_reg(A_CHI, 32'h0, 4'hF);
    wr_reg(A_CLO, 32'h20, 4'hF);
    while (cyc < 40) begin
      check("irq_level", timer_interrupt, (cyc >= 33));
      @(negedge clk);
    end
    wr_reg(A_CHI, 32'hFFFF_FFFF, 4'hF);
    check("irq_still_high_at_ack", irq_at_ack, 1);
    check("irq_dropped", timer_interrupt, 0);

    // Carry and snapshot coherency
    wr_reg(A_MHI, 32'h0, 4'hF);
    wr_reg(A_MLO, 32'hFFFF_FFFE, 4'hF);
    rd_reg("carry_lo_pre", A_MLO, 32'hFFFF_FFFF);
    rd_reg("carry_hi_snapshot", A_MHI, 32'h0);
    rd_reg("carry_lo_post", A_MLO, 32'h3);
    rd_reg("carry_hi_post", A_MHI, 32'h1);

    // 64-bit wrap from all-ones to zero
    wr_reg(A_MHI, 32'hFFFF_FFFF, 4'hF);
    wr_reg(A_MLO, 32'hFFFF_FFFE, 4'hF);
    rd_reg("wrap_lo_allones", A_MLO, 32'hFFFF_FFFF);
    rd_reg("wrap_lo_after", A_MLO, 32'h1);
    rd_reg("wrap_hi_after", A_MHI, 32'h0);

    // Prescaler DIV = 3: one increment every 4 cycles
    wr_reg(A_MHI, 32'h0, 4'hF);
    wr_reg(A_MLO, 32'h0, 4'hF);
    wr_reg(A_CTRL, 32'h0003_0001, 4'hF);
    for (int i = 0; i < 8; i++) rd_reg("prescale_mtime", A_MLO, pre_tab[i]);

    // EN = 0 freezes mtime
    wr_reg(A_CTRL, 32'h0003_0000, 4'hF);
    rd_reg("freeze_start", A_MLO, 32'd6);
    repeat (20) @(negedge clk);
    rd_reg("freeze_after_20", A_MLO, 32'd6);
    rd_reg("ctrl_readback_off", A_CTRL, 32'h0003_0000);

    // Write/tick collision with DIV = 0
    wr_reg(A_CTRL, 32'h0000_0001, 4'hF);
    wr_reg(A_MLO, 32'h100, 4'hF);
    rd_reg("collision_first", A_MLO, 32'h101);
    rd_reg("collision_second", A_MLO, 32'h103);
    wr_reg(A_MLO, 32'hDEAD_BEEF, 4'h0);
    rd_reg("be_zero_noop", A_MLO, 32'h107);

    // Byte-lane merge and register readback
    wr_reg(A_CLO, 32'hAABB_CCDD, 4'b0010);
    rd_reg("cmp_lo_bytemerge", A_CLO, 32'h0000_CC20);
    rd_reg("cmp_hi_readback", A_CHI, 32'hFFFF_FFFF);
    rd_reg("ctrl_readback", A_CTRL, 32'h0000_0001);

    // Unmapped window
    wr_reg(5'h1C, 32'hFFFF_FFFF, 4'hF);
    rd_reg("unmapped_18", 5'h18, 32'h0);
    rd_reg("unmapped_1c", 5'h1C, 32'h0);

    // req held high for three reads: acks on alternate cycles only
    bus_req  = 1'b1;
    bus_we   = 1'b0;
    bus_addr = A_CTRL;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("hs_ack", bus_ack, (i % 2 == 0));
      check("hs_rdata", bus_rdata, (i % 2 == 0) ? 64'h1 : 64'h0);
    end
    bus_req = 1'b0;
    @(negedge clk);
    check("hs_ack_idle", bus_ack, 0);

    // Reset asserted during the ack cycle
    bus_req  = 1'b1;
    bus_addr = A_CTRL;
    @(negedge clk);
    check("midack_ack_before", bus_ack, 1);
    #2 rst = 1'b0;
    #1;
    check("midack_ack_cleared", bus_ack, 0);
    check("midack_rdata_cleared", bus_rdata, 0);
    check("midack_irq_cleared", timer_interrupt, 0);
    bus_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    rd_reg("post_rst_mtime", A_MLO, 32'h0);
    rd_reg("post_rst_cmp_lo", A_CLO, 32'hFFFF_FFFF);
    rd_reg("post_rst_cmp_hi", A_CHI, 32'hFFFF_FFFF);
    rd_reg("post_rst_ctrl", A_CTRL, 32'h0000_0001);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
